// File: rtl/serial_frame_sequencer_if.sv
// Bundle of the serial-line inputs and the byte/verdict outputs of the
// frame sequencer. The line-side driver uses master; the sequencer uses slave.
interface serial_frame_sequencer_if;
    logic       bit_en;
    logic       bit_in;
    logic       abort;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       multicast;
    logic       busy;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       addr_miss;

    modport master (
        output bit_en, bit_in, abort,
        input  byte_out, byte_valid, multicast, busy,
        input  frame_ok, frame_err, err_code, addr_miss
    );

    modport slave (
        input  bit_en, bit_in, abort,
        output byte_out, byte_valid, multicast, busy,
        output frame_ok, frame_err, err_code, addr_miss
    );
endinterface

// File: rtl/serial_frame_sequencer.sv
// Bit-serial frame receiver: hunts for the start delimiter, then walks the
// address, length, payload and checksum fields. Payload bytes of accepted
// frames are strobed out; the frame verdict is reported as one-cycle pulses.
// Every output is a flop; a byte's results appear the cycle after its 8th bit.
module serial_frame_sequencer #(
    parameter logic [7:0] MY_ADDR = 8'h1E,
    parameter int unsigned MAX_LEN = 16,
    parameter logic [7:0] SFD     = 8'hD5
) (
    input  logic                     clk,
    input  logic                     rst,
    serial_frame_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_HUNT = 3'd0,
        ST_ADDR = 3'd1,
        ST_LEN  = 3'd2,
        ST_DATA = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    // Running frame checksum: XOR accumulation of one more byte.
    function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] window_q, window_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] chk_q, chk_d;
    logic [7:0] remain_q, remain_d;
    logic       skip_q, skip_d;

    logic [7:0] byte_out_q, byte_out_d;
    logic       byte_valid_q, byte_valid_d;
    logic       multicast_q, multicast_d;
    logic       busy_q, busy_d;
    logic       frame_ok_q, frame_ok_d;
    logic       frame_err_q, frame_err_d;
    logic [1:0] err_code_q, err_code_d;
    logic       addr_miss_q, addr_miss_d;

    logic [7:0] win_s;
    logic [7:0] byte_s;
    logic       byte_done_s;

    assign win_s       = {window_q[6:0], bus.bit_in};
    assign byte_s      = {shift_q[6:0], bus.bit_in};
    assign byte_done_s = (bit_cnt_q == 3'd7);

    // Next-state, datapath and output computation for one clock.
    always_comb begin
        state_d      = state_q;
        window_d     = window_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        chk_d        = chk_q;
        remain_d     = remain_q;
        skip_d       = skip_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        multicast_d  = multicast_q;
        frame_ok_d   = 1'b0;
        frame_err_d  = 1'b0;
        err_code_d   = err_code_q;
        addr_miss_d  = 1'b0;

        if (bus.abort && (state_q != ST_HUNT)) begin
            // Abort wins over a coincident bit; that bit is dropped.
            state_d   = ST_HUNT;
            window_d  = 8'h00;
            bit_cnt_d = 3'd0;
            if (!skip_q) begin
                frame_err_d = 1'b1;
                err_code_d  = 2'b11;
            end else begin
                frame_err_d = 1'b0;
            end
        end else if (bus.bit_en && !bus.abort) begin
            if (state_q == ST_HUNT) begin
                window_d = win_s;
            end else begin
                shift_d   = byte_s;
                bit_cnt_d = bit_cnt_q + 3'd1;
            end

            case (state_q)
                ST_HUNT: begin
                    if (win_s == SFD) begin
                        state_d     = ST_ADDR;
                        bit_cnt_d   = 3'd0;
                        chk_d       = 8'h00;
                        skip_d      = 1'b0;
                        multicast_d = 1'b0;
                        shift_d     = 8'h00;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_ADDR: begin
                    if (byte_done_s) begin
                        chk_d   = chk_fold(chk_q, byte_s);
                        state_d = ST_LEN;
                        if (byte_s[7]) begin
                            multicast_d = 1'b1;
                        end else if (byte_s == MY_ADDR) begin
                            multicast_d = 1'b0;
                        end else begin
                            addr_miss_d = 1'b1;
                            skip_d      = 1'b1;
                        end
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_LEN: begin
                    if (byte_done_s) begin
                        chk_d = chk_fold(chk_q, byte_s);
                        if ((byte_s == 8'h00) || (byte_s > MAX_LEN_B)) begin
                            state_d  = ST_HUNT;
                            window_d = 8'h00;
                            if (!skip_q) begin
                                frame_err_d = 1'b1;
                                err_code_d  = 2'b01;
                            end else begin
                                frame_err_d = 1'b0;
                            end
                        end else begin
                            remain_d = byte_s;
                            state_d  = ST_DATA;
                        end
                    end else begin
                        state_d = ST_LEN;
                    end
                end
                ST_DATA: begin
                    if (byte_done_s) begin
                        chk_d    = chk_fold(chk_q, byte_s);
                        remain_d = remain_q - 8'd1;
                        if (!skip_q) begin
                            byte_out_d   = byte_s;
                            byte_valid_d = 1'b1;
                        end else begin
                            byte_valid_d = 1'b0;
                        end
                        if (remain_q == 8'd1) begin
                            state_d = ST_CHK;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_CHK: begin
                    if (byte_done_s) begin
                        state_d  = ST_HUNT;
                        window_d = 8'h00;
                        if (skip_q) begin
                            frame_ok_d = 1'b0;
                        end else if (byte_s == chk_q) begin
                            frame_ok_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = 2'b10;
                        end
                    end else begin
                        state_d = ST_CHK;
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    window_d  = 8'h00;
                    bit_cnt_d = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != ST_HUNT);
    end

    // State, datapath and output registers; async reset returns to HUNT silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            window_q     <= 8'h00;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            chk_q        <= 8'h00;
            remain_q     <= 8'h00;
            skip_q       <= 1'b0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            multicast_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= 2'b00;
            addr_miss_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            window_q     <= window_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            chk_q        <= chk_d;
            remain_q     <= remain_d;
            skip_q       <= skip_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            multicast_q  <= multicast_d;
            busy_q       <= busy_d;
            frame_ok_q   <= frame_ok_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
            addr_miss_q  <= addr_miss_d;
        end
    end

    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign bus.multicast  = multicast_q;
    assign bus.busy       = busy_q;
    assign bus.frame_ok   = frame_ok_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_code   = err_code_q;
    assign bus.addr_miss  = addr_miss_q;

endmodule

// File: tb/tb_serial_frame_sequencer.sv
// Directed bench for serial_frame_sequencer. Stimulus tasks push the expected
// pulse (kind, data, arrival cycle) into a queue; a monitor on the falling
// edge pops and compares every pulse the DUT raises.
module tb_serial_frame_sequencer;

    localparam int K_BYTE = 0;
    localparam int K_OK   = 1;
    localparam int K_ERR  = 2;
    localparam int K_MISS = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       mc;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic gap    = 1'b0;
    exp_t exp_q[$];

    serial_frame_sequencer_if sif();

    serial_frame_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected pulse arrives at the falling edge after the edge sampling the current bit.
    task automatic push(input int kind, input logic [7:0] data, input logic mc);
        exp_t e;
        e.kind = kind;
        e.data = data;
        e.mc   = mc;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic take(input int kind, input logic [7:0] data, input logic mc);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse kind=%0d data=%0h cycle=%0d", kind, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.data !== data || e.mc !== mc || e.cyc != cyc) begin
                errors++;
                $display("FAIL pulse actual kind=%0d data=%0h mc=%0b cyc=%0d required kind=%0d data=%0h mc=%0b cyc=%0d",
                         kind, data, mc, cyc, e.kind, e.data, e.mc, e.cyc);
            end
        end
    endtask

    // Monitor: every pulse seen on a falling edge must match the next expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (sif.byte_valid) take(K_BYTE, sif.byte_out, 1'b0);
            if (sif.addr_miss)  take(K_MISS, 8'h00, 1'b0);
            if (sif.frame_ok)   take(K_OK, 8'h00, sif.multicast);
            if (sif.frame_err)  take(K_ERR, {6'd0, sif.err_code}, 1'b0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sif.bit_en = 1'b0;
            sif.abort  = 1'b0;
        end
    endtask

    task automatic send_bit(input logic b, input logic ab);
        if (gap) idle(1);
        @(negedge clk);
        sif.bit_en = 1'b1;
        sif.bit_in = b;
        sif.abort  = ab;
    endtask

    task automatic send_byte(input logic [7:0] b, input int kind, input logic [7:0] d, input logic mc);
        for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
        if (kind >= 0) push(kind, d, mc);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_byte_out"},   {24'd0, sif.byte_out}, 32'd0);
        check({tag, "_byte_valid"}, {31'd0, sif.byte_valid}, 32'd0);
        check({tag, "_multicast"},  {31'd0, sif.multicast}, 32'd0);
        check({tag, "_busy"},       {31'd0, sif.busy}, 32'd0);
        check({tag, "_frame_ok"},   {31'd0, sif.frame_ok}, 32'd0);
        check({tag, "_frame_err"},  {31'd0, sif.frame_err}, 32'd0);
        check({tag, "_err_code"},   {30'd0, sif.err_code}, 32'd0);
        check({tag, "_addr_miss"},  {31'd0, sif.addr_miss}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        sif.bit_en = 1'b0;
        sif.bit_in = 1'b0;
        sif.abort  = 1'b0;
        idle(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Good unicast frame: 1E^02^AA^55 = E3.
        send_byte(8'hD5, -1, 8'h00, 1'b0);
        idle(1);
        check("busy_after_sfd", {31'd0, sif.busy}, 32'd1);
        send_byte(8'h1E, -1, 8'h00, 1'b0);
        send_byte(8'h02, -1, 8'h00, 1'b0);
        send_byte(8'hAA, K_BYTE, 8'hAA, 1'b0);
        send_byte(8'h55, K_BYTE, 8'h55, 1'b0);
        send_byte(8'hE3, K_OK, 8'h00, 1'b0);
        idle(1);
        check("busy_after_chk", {31'd0, sif.busy}, 32'd0);
        check("unicast_mc", {31'd0, sif.multicast}, 32'd0);

        // Multicast frame: 80^02^AA^55 = 7D.
        send_byte(8'hD5, -1, 8'h00, 1'b0);
        send_byte(8'h80, -1, 8'h00, 1'b0);
        send_byte(8'h02, -1, 8'h00, 1'b0);
        send_byte(8'hAA, K_BYTE, 8'hAA, 1'b0);
        send_byte(8'h55, K_BYTE, 8'h55, 1'b0);
        send_byte(8'h7D, K_OK, 8'h00, 1'b1);
        idle(2);
        check("mc_held", {31'd0, sif.multicast}, 32'd1);

        // Address miss, with idle cycles between bits: skipped silently.
        gap = 1'b1;
        send_byte(8'hD5, -1, 8'h00, 1'b0);
        send_byte(8'h1F, K_MISS, 8'h00, 1'b0);
        send_byte(8'h02, -1, 8'h00, 1'b0);
        send_byte(8'hAA, -1, 8'h00, 1'b0);
        send_byte(8'h55, -1, 8'h00, 1'b0);
        idle(1);
        check("miss_busy_before_chk", {31'd0, sif.busy}, 32'd1);
        check("miss_mc_cleared", {31'd0, sif.multicast}, 32'd0);
        send_byte(8'hE2, -1, 8'h00, 1'b0);
        gap = 1'b0;
        idle(1);
        check("miss_busy_fall", {31'd0, sif.busy}, 32'd0);

        // Length errors: zero and one above the maximum.
        send_byte(8'hD5, -1, 8'h00, 1'b0);
        send_byte(8'h1E, -1, 8'h00, 1'b0);
        send_byte(8'h00, K_ERR, 8'h01, 1'b0);
        idle(1);
        check("len0_busy", {31'd0, sif.busy}, 32'd0);
        send_byte(8'hD5, -1, 8'h00, 1'b0);
        send_byte(8'h1E, -1, 8'h00, 1'b0);
        send_byte(8'h11, K_ERR, 8'h01, 1'b0);
        idle(3);
        check("len17_busy", {31'd0, sif.busy}, 32'd0);
        check("len_code_held", {30'd0, sif.err_code}, 32'd1);

        // Bad checksum, then a good frame starting on the very next bit.
        send_byte(8'hD5, -1, 8'h00, 1'b0);
        send_byte(8'h1E, -1, 8'h00, 1'b0);
        send_byte(8'h02, -1, 8'h00, 1'b0);
        send_byte(8'hAA, K_BYTE, 8'hAA, 1'b0);
        send_byte(8'h55, K_BYTE, 8'h55, 1'b0);
        send_byte(8'hE4, K_ERR, 8'h02, 1'b0);
        send_byte(8'hD5, -1, 8'h00, 1'b0);
        send_byte(8'h1E, -1, 8'h00, 1'b0);
        send_byte(8'h01, -1, 8'h00, 1'b0);
        send_byte(8'h3C, K_BYTE, 8'h3C, 1'b0);
        send_byte(8'h23, K_OK, 8'h00, 1'b0);
        idle(1);
        check("b2b_code_held", {30'd0, sif.err_code}, 32'd2);

        // Abort on the 4th payload bit of AA (bits 1,0,1 then 0 with abort).
        send_byte(8'hD5, -1, 8'h00, 1'b0);
        send_byte(8'h1E, -1, 8'h00, 1'b0);
        send_byte(8'h02, -1, 8'h00, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        push(K_ERR, 8'h03, 1'b0);
        idle(1);
        check("abort_busy", {31'd0, sif.busy}, 32'd0);
        check("abort_code", {30'd0, sif.err_code}, 32'd3);
        send_bit(1'b1, 1'b1);
        idle(2);

        // Reset in the middle of LEN: silent return, then a good frame.
        send_byte(8'hD5, -1, 8'h00, 1'b0);
        send_byte(8'h1E, -1, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        @(negedge clk);
        rst        = 1'b1;
        sif.bit_en = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        idle(1);
        send_byte(8'hD5, -1, 8'h00, 1'b0);
        send_byte(8'h1E, -1, 8'h00, 1'b0);
        send_byte(8'h02, -1, 8'h00, 1'b0);
        send_byte(8'hAA, K_BYTE, 8'hAA, 1'b0);
        send_byte(8'h55, K_BYTE, 8'h55, 1'b0);
        send_byte(8'hE3, K_OK, 8'h00, 1'b0);
        idle(4);

        check("pending_expectations", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
